bolt_manager: RTL and testbench

Parametrised projectile-slot manager for one shooter (player or invader side) in the VGA game core. It owns BOLT_MAX bolt slots and allocates a free slot on each fire event. It latches the launch coordinate for the bolt sprite, and clears slots on target hit or border exit. Hit events are aggregated per frame and reported to the game controller as a frame-aligned pulse plus a saturating hit counter.

---
 rtl/bolt_pkg.sv | 36 +++
 rtl/bolt_slot.sv | 65 ++++++
 rtl/bolt_manager.sv | 141 ++++++++++++++
 tb/tb_bolt_manager.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bolt_pkg.sv
// Shared types and constants for the bolt slot manager.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package bolt_pkg;

  // Pixel coordinate width used by the VGA game core.
  localparam int COORD_W = 11;

  // Retirement rows: player bolts leave at the top, invader bolts at the bottom.
  localparam int T_BORDER = 5;
  localparam int B_BORDER = 460;

  // Per-slot life cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LAUNCH = 2'd1,
    FLYING = 2'd2
  } slotState_t;

  // Launch coordinate handed to the bolt sprite.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Number of set bits in a slot mask (up to 16 slots).
  function automatic logic [4:0] popCount(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bolt_slot.sv
// One bolt slot: FREE -> LAUNCH on alloc, LAUNCH -> FLYING next cycle, FLYING -> FREE on kill/border/flush.
// Latency: state change one cycle after the causing input; exs/load/free/kill decode the current state.
// Backpressure: none; alloc is only raised by the owner while the slot reports free.
module bolt_slot
  import bolt_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic alloc,
  input  logic bltReq,
  input  logic tgtReq,
  input  logic atBorder,
  input  logic flush,
  output logic exs,
  output logic load,
  output logic kill,
  output logic free
);

  slotState_t state;
  slotState_t nxtState;

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= FREE;
    end else begin
      state <= nxtState;
    end
  end

  // Next state and decoded outputs; a bolt in LAUNCH ignores sprite requests
  // because the sprite still carries data from the previous occupant.
  always_comb begin
    nxtState = state;
    exs      = 1'b0;
    load     = 1'b0;
    kill     = 1'b0;
    free     = 1'b0;
    case (state)
      FREE: begin
        free = 1'b1;
        if (alloc && !flush) begin
          nxtState = LAUNCH;
        end
      end
      LAUNCH: begin
        exs      = 1'b1;
        load     = 1'b1;
        nxtState = flush ? FREE : FLYING;
      end
      FLYING: begin
        exs  = 1'b1;
        kill = bltReq && tgtReq && !flush;
        if (flush || (bltReq && (tgtReq || atBorder))) begin
          nxtState = FREE;
        end
      end
      default: begin
        nxtState = FREE;
      end
    endcase
  end

endmodule

// File: rtl/bolt_manager.sv
// Bolt slot manager: allocates the lowest free slot per fire edge, latches launch XY, aggregates hits per frame.
// Latency: accept -> bltLoad/bltExs next cycle; kill/border -> bltExs clear next cycle; srtFrm -> hitPulse next cycle.
// Backpressure: none; fire edges with no free slot (or during cooldown) are dropped, never queued.
// Build option: define BOLT_COOLDOWN_EN to force COOLDOWN_FRAMES frames between launches.
module bolt_manager
  import bolt_pkg::*;
#(
  parameter int BOLT_MAX        = 4,
  parameter int BORDER_Y        = T_BORDER,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 10
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                enable,
  input  logic                srtFrm,
  input  logic [10:0]         pixelY,
  input  logic                fireKey,
  input  logic [10:0]         srcX,
  input  logic [10:0]         srcY,
  input  logic [BOLT_MAX-1:0] bltReq,
  input  logic                tgtReq,
  output logic [BOLT_MAX-1:0] bltExs,
  output logic [BOLT_MAX-1:0] bltLoad,
  output logic [10:0]         bltX,
  output logic [10:0]         bltY,
  output logic                hitPulse,
  output logic [CNT_W-1:0]    hitCnt,
  output logic [4:0]          freeCnt
);

  logic                fireKeyD;
  logic                fireEdge;
  logic                coolOk;
  logic                accept;
  logic                atBorder;
  logic                flush;
  logic                anyKill;
  logic                hitLatch;
  logic [BOLT_MAX-1:0] slotFree;
  logic [BOLT_MAX-1:0] slotKill;
  logic [BOLT_MAX-1:0] lowestFree;
  logic [BOLT_MAX-1:0] alloc;
  coord_t              launchPos;

  assign flush    = !enable;
  assign atBorder = (pixelY == COORD_W'(BORDER_Y));
  assign fireEdge = fireKey && !fireKeyD;
  assign anyKill  = |slotKill;

  // Isolate the lowest set bit of the free mask; slots freeing this cycle are
  // still FLYING here, so they only become eligible next cycle.
  assign lowestFree = slotFree & (~slotFree + BOLT_MAX'(1));
  assign accept     = fireEdge && enable && (|slotFree) && coolOk;
  assign alloc      = accept ? lowestFree : '0;

  // Registered copy of the fire level for edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fireKeyD <= 1'b0;
    end else begin
      fireKeyD <= fireKey;
    end
  end

`ifdef BOLT_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  logic [CD_W-1:0] coolCnt;

  // Frame-based cooldown: reload on launch, count frames down to zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coolCnt <= '0;
    end else if (flush) begin
      coolCnt <= '0;
    end else if (accept) begin
      coolCnt <= CD_W'(COOLDOWN_FRAMES);
    end else if (srtFrm && (coolCnt != '0)) begin
      coolCnt <= coolCnt - CD_W'(1);
    end
  end

  assign coolOk = (coolCnt == '0);
`else
  assign coolOk = 1'b1;
`endif

  // Launch coordinate held until the next accepted fire.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      launchPos <= '0;
    end else if (accept) begin
      launchPos <= '{x: srcX, y: srcY};
    end
  end

  assign bltX = launchPos.x;
  assign bltY = launchPos.y;

  // Frame hit latch, frame-aligned pulse and saturating hit-frame counter.
  // A kill coinciding with srtFrm seeds the latch for the frame just starting.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitLatch <= 1'b0;
      hitPulse <= 1'b0;
      hitCnt   <= '0;
    end else if (flush) begin
      hitLatch <= 1'b0;
      hitPulse <= 1'b0;
    end else begin
      hitPulse <= srtFrm && hitLatch;
      if (srtFrm) begin
        hitLatch <= anyKill;
        if (hitLatch && (hitCnt != '1)) begin
          hitCnt <= hitCnt + CNT_W'(1);
        end
      end else if (anyKill) begin
        hitLatch <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < BOLT_MAX; i++) begin : gSlot
    bolt_slot uSlot (
      .clk      (clk),
      .resetN   (resetN),
      .alloc    (alloc[i]),
      .bltReq   (bltReq[i]),
      .tgtReq   (tgtReq),
      .atBorder (atBorder),
      .flush    (flush),
      .exs      (bltExs[i]),
      .load     (bltLoad[i]),
      .kill     (slotKill[i]),
      .free     (slotFree[i])
    );
  end

  assign freeCnt = popCount(16'(slotFree));

endmodule

// File: tb/tb_bolt_manager.sv
// Self-checking bench for bolt_manager: directed scenarios plus randomized traffic against a slot-list model.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked after the following edge.
// Backpressure: n/a.
module tb_bolt_manager;

  localparam int BM = 4;
  localparam int BY = 5;
  localparam int CF = 2;
  localparam int CW = 2;

  logic          clk;
  logic          resetN;
  logic          enable;
  logic          srtFrm;
  logic [10:0]   pixelY;
  logic          fireKey;
  logic [10:0]   srcX;
  logic [10:0]   srcY;
  logic [BM-1:0] bltReq;
  logic          tgtReq;
  logic [BM-1:0] bltExs;
  logic [BM-1:0] bltLoad;
  logic [10:0]   bltX;
  logic [10:0]   bltY;
  logic          hitPulse;
  logic [CW-1:0] hitCnt;
  logic [4:0]    freeCnt;

  bolt_manager #(
    .BOLT_MAX(BM), .BORDER_Y(BY), .COOLDOWN_FRAMES(CF), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .srtFrm(srtFrm), .pixelY(pixelY),
    .fireKey(fireKey), .srcX(srcX), .srcY(srcY), .bltReq(bltReq), .tgtReq(tgtReq),
    .bltExs(bltExs), .bltLoad(bltLoad), .bltX(bltX), .bltY(bltY),
    .hitPulse(hitPulse), .hitCnt(hitCnt), .freeCnt(freeCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Reference model: which slots hold a bolt, and the edge at which each was launched.
  bit mBusy[BM];
  int mLaunchAt[BM];
  int mNow = 0;
  bit mPrev;
  bit mLatch;
  int mHitCnt;
  int mCool;
  int mX, mY;
  int mLoad;
  bit mPulse;

  task automatic modelReset();
    for (int i = 0; i < BM; i++) begin
      mBusy[i] = 0;
      mLaunchAt[i] = -10;
    end
    mPrev = 0; mLatch = 0; mHitCnt = 0; mCool = 0;
    mX = 0; mY = 0; mLoad = 0; mPulse = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    bit startBusy[BM];
    bit anyKill;
    bit edgeSeen;
    bit accept;
    int pick;
    if (!resetN) begin
      modelReset();
      mNow++;
      return;
    end
    edgeSeen = fireKey && !mPrev;
    mPrev = fireKey;
    mLoad = 0;
    mPulse = 0;
    if (!enable) begin
      for (int i = 0; i < BM; i++) mBusy[i] = 0;
      mLatch = 0;
      mCool = 0;
      mNow++;
      return;
    end
    startBusy = mBusy;
    anyKill = 0;
    for (int i = 0; i < BM; i++) begin
      // a bolt launched on the previous edge is still fresh and ignores sprite data
      if (mBusy[i] && (mLaunchAt[i] != mNow - 1) && bltReq[i]) begin
        if (tgtReq) anyKill = 1;
        if (tgtReq || pixelY == BY) mBusy[i] = 0;
      end
    end
    pick = -1;
    for (int i = 0; i < BM; i++) if (!startBusy[i] && pick < 0) pick = i;
    accept = edgeSeen && (pick >= 0);
`ifdef BOLT_COOLDOWN_EN
    accept = accept && (mCool == 0);
`endif
    if (accept) begin
      mBusy[pick] = 1;
      mLaunchAt[pick] = mNow;
      mX = srcX;
      mY = srcY;
      mLoad = 1 << pick;
    end
    if (srtFrm) begin
      mPulse = mLatch;
      if (mLatch && mHitCnt < (1 << CW) - 1) mHitCnt++;
      mLatch = anyKill;
    end else begin
      mLatch = mLatch | anyKill;
    end
    if (accept) mCool = CF;
    else if (srtFrm && mCool > 0) mCool--;
    mNow++;
  endtask

  function automatic logic [BM-1:0] busyVec();
    logic [BM-1:0] v;
    v = '0;
    for (int i = 0; i < BM; i++) v[i] = mBusy[i];
    return v;
  endfunction

  function automatic int freeCount();
    int c;
    c = 0;
    for (int i = 0; i < BM; i++) if (!mBusy[i]) c++;
    return c;
  endfunction

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fireKey = 0; srtFrm = 0; bltReq = '0; tgtReq = 0; pixelY = 11'd100;
  endtask

  // Two frame strobes with fire released, clearing any cooldown.
  task automatic gap();
    idle(); tick();
    srtFrm = 1; tick(); srtFrm = 0; tick();
    srtFrm = 1; tick(); srtFrm = 0; tick();
  endtask

  task automatic test_reset();
    resetN = 0; enable = 1; srcX = '0; srcY = '0; idle();
    repeat (3) tick();
    nVec++; if (bltExs !== 4'b0000) begin nErr++; $display("FAIL reset_exs: got %b want 0000", bltExs); end
    nVec++; if (bltLoad !== 4'b0000) begin nErr++; $display("FAIL reset_load: got %b want 0000", bltLoad); end
    nVec++; if (bltX !== 11'd0 || bltY !== 11'd0) begin nErr++; $display("FAIL reset_xy: got %0d,%0d want 0,0", bltX, bltY); end
    nVec++; if (hitPulse !== 1'b0 || hitCnt !== 2'd0) begin nErr++; $display("FAIL reset_hit: got %b/%0d want 0/0", hitPulse, hitCnt); end
    nVec++; if (freeCnt !== 5'd4) begin nErr++; $display("FAIL reset_free: got %0d want 4", freeCnt); end
    resetN = 1;
    tick();
  endtask

  task automatic test_fire_basic();
    srcX = 11'd320; srcY = 11'd440; fireKey = 1;
    tick();
    nVec++; if (bltLoad !== 4'b0001) begin nErr++; $display("FAIL fire_load: got %b want 0001", bltLoad); end
    nVec++; if (bltExs !== 4'b0001) begin nErr++; $display("FAIL fire_exs: got %b want 0001", bltExs); end
    nVec++; if (bltX !== 11'd320 || bltY !== 11'd440) begin nErr++; $display("FAIL fire_xy: got %0d,%0d want 320,440", bltX, bltY); end
    nVec++; if (freeCnt !== 5'd3) begin nErr++; $display("FAIL fire_free: got %0d want 3", freeCnt); end
    fireKey = 0; srcX = 11'd7;
    tick();
    nVec++; if (bltLoad !== 4'b0000 || bltExs !== 4'b0001) begin nErr++; $display("FAIL fire_hold: load %b exs %b want 0000/0001", bltLoad, bltExs); end
    nVec++; if (bltX !== 11'd320) begin nErr++; $display("FAIL fire_xhold: got %0d want 320", bltX); end
  endtask

  task automatic test_fill();
    logic [BM-1:0] want;
    for (int k = 1; k < BM; k++) begin
      gap();
      srcX = 11'(100 + k); fireKey = 1;
      tick();
      want = BM'(1) << k;
      nVec++; if (bltLoad !== want) begin nErr++; $display("FAIL fill_load%0d: got %b want %b", k, bltLoad, want); end
    end
    gap();
    fireKey = 1;
    tick();
    nVec++; if (bltLoad !== 4'b0000) begin nErr++; $display("FAIL fill_fifth: got %b want 0000", bltLoad); end
    nVec++; if (freeCnt !== 5'd0 || bltExs !== 4'b1111) begin nErr++; $display("FAIL fill_full: free %0d exs %b want 0/1111", freeCnt, bltExs); end
    nVec++; if (bltX !== 11'd103) begin nErr++; $display("FAIL fill_xkeep: got %0d want 103", bltX); end
    idle(); tick();
  endtask

  task automatic test_kill();
    bltReq = 4'b0010; tgtReq = 1;
    tick();
    nVec++; if (bltExs !== 4'b1101) begin nErr++; $display("FAIL kill_exs: got %b want 1101", bltExs); end
    nVec++; if (freeCnt !== 5'd1) begin nErr++; $display("FAIL kill_free: got %0d want 1", freeCnt); end
    idle(); tick();
    srtFrm = 1; tick(); srtFrm = 0;
    nVec++; if (hitPulse !== 1'b1 || hitCnt !== 2'd1) begin nErr++; $display("FAIL kill_frame: pulse %b cnt %0d want 1/1", hitPulse, hitCnt); end
    tick();
    nVec++; if (hitPulse !== 1'b0) begin nErr++; $display("FAIL kill_pulse_once: got %b want 0", hitPulse); end
  endtask

  task automatic test_border();
    bltReq = 4'b0100; pixelY = 11'd5; tgtReq = 0;
    tick();
    nVec++; if (bltExs !== 4'b1001) begin nErr++; $display("FAIL border_exs: got %b want 1001", bltExs); end
    idle(); tick();
    srtFrm = 1; tick(); srtFrm = 0;
    nVec++; if (hitPulse !== 1'b0 || hitCnt !== 2'd1) begin nErr++; $display("FAIL border_frame: pulse %b cnt %0d want 0/1", hitPulse, hitCnt); end
  endtask

  task automatic test_double_kill();
    int pulses;
    bltReq = 4'b1001; tgtReq = 1; pixelY = 11'd5;
    tick();
    nVec++; if (bltExs !== 4'b0000) begin nErr++; $display("FAIL dkill_exs: got %b want 0000", bltExs); end
    idle();
    srtFrm = 1; tick(); srtFrm = 0;
    pulses = hitPulse;
    tick(); pulses += hitPulse;
    tick(); pulses += hitPulse;
    nVec++; if (pulses != 1) begin nErr++; $display("FAIL dkill_pulses: got %0d want 1", pulses); end
    nVec++; if (hitCnt !== 2'd2) begin nErr++; $display("FAIL dkill_cnt: got %0d want 2", hitCnt); end
    // three more hit frames; a fresh bolt must survive a stale kill request first
    for (int k = 1; k <= 3; k++) begin
      gap();
      fireKey = 1; tick();
      fireKey = 0; bltReq = 4'b0001; tgtReq = 1;
      tick();
      nVec++; if (bltExs !== 4'b0001) begin nErr++; $display("FAIL stale_kill%0d: got %b want 0001", k, bltExs); end
      tick();
      nVec++; if (bltExs !== 4'b0000) begin nErr++; $display("FAIL sat_kill%0d: got %b want 0000", k, bltExs); end
      idle();
      srtFrm = 1; tick(); srtFrm = 0;
      nVec++; if (hitCnt !== 2'd3 || hitPulse !== 1'b1) begin nErr++; $display("FAIL sat_cnt%0d: cnt %0d pulse %b want 3/1", k, hitCnt, hitPulse); end
    end
  endtask

`ifdef BOLT_COOLDOWN_EN
  task automatic test_cooldown();
    gap();
    fireKey = 1; tick();
    nVec++; if (bltLoad !== 4'b0001) begin nErr++; $display("FAIL cool_first: got %b want 0001", bltLoad); end
    fireKey = 0; srtFrm = 1; tick(); srtFrm = 0;
    fireKey = 1; tick();
    nVec++; if (bltLoad !== 4'b0000) begin nErr++; $display("FAIL cool_reject: got %b want 0000", bltLoad); end
    fireKey = 0; tick();
    srtFrm = 1; tick(); srtFrm = 0;
    fireKey = 1; tick();
    nVec++; if (bltLoad !== 4'b0010) begin nErr++; $display("FAIL cool_second: got %b want 0010", bltLoad); end
    idle(); tick();
  endtask
`endif

  task automatic test_flush();
    gap();
    fireKey = 1; tick();
    fireKey = 0; tick();
    nVec++; if (bltExs === 4'b0000) begin nErr++; $display("FAIL flush_pre: got %b want nonzero", bltExs); end
    enable = 0; tick();
    nVec++; if (bltExs !== 4'b0000 || freeCnt !== 5'd4) begin nErr++; $display("FAIL flush_exs: exs %b free %0d want 0000/4", bltExs, freeCnt); end
    fireKey = 1; tick();
    nVec++; if (bltLoad !== 4'b0000 || bltExs !== 4'b0000) begin nErr++; $display("FAIL flush_fire: load %b exs %b want 0000/0000", bltLoad, bltExs); end
    nVec++; if (hitCnt !== 2'd3) begin nErr++; $display("FAIL flush_cnt: got %0d want 3", hitCnt); end
    enable = 1; idle(); tick();
  endtask

  task automatic test_reset_midflight();
    gap();
    fireKey = 1; tick();
    fireKey = 0; tick();
    bltReq = 4'b0001; tgtReq = 1; tick();
    idle();
    #2 resetN = 0;
    #1;
    modelReset();
    nVec++; if (bltExs !== 4'b0000 || hitCnt !== 2'd0 || bltX !== 11'd0) begin nErr++; $display("FAIL areset: exs %b cnt %0d x %0d want 0000/0/0", bltExs, hitCnt, bltX); end
    @(posedge clk); #1;
    tick();
    resetN = 1;
    srtFrm = 1; tick(); srtFrm = 0;
    nVec++; if (hitPulse !== 1'b0 || bltLoad !== 4'b0000 || freeCnt !== 5'd4) begin nErr++; $display("FAIL areset_release: pulse %b load %b free %0d want 0/0000/4", hitPulse, bltLoad, freeCnt); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      enable  = ($urandom_range(0, 39) != 0);
      srtFrm  = ($urandom_range(0, 14) == 0);
      pixelY  = ($urandom_range(0, 5) == 0) ? 11'(BY) : 11'($urandom_range(0, 524));
      if ($urandom_range(0, 2) == 0) fireKey = ~fireKey;
      srcX    = 11'($urandom_range(0, 639));
      srcY    = 11'($urandom_range(0, 479));
      bltReq  = ($urandom_range(0, 2) == 0) ? BM'($urandom) : '0;
      tgtReq  = ($urandom_range(0, 2) == 0);
      tick();
      nVec++; if (bltExs !== busyVec()) begin nErr++; $display("FAIL rnd_exs@%0d: got %b want %b", n, bltExs, busyVec()); end
      nVec++; if (bltLoad !== BM'(mLoad)) begin nErr++; $display("FAIL rnd_load@%0d: got %b want %b", n, bltLoad, BM'(mLoad)); end
      nVec++; if (bltX !== 11'(mX) || bltY !== 11'(mY)) begin nErr++; $display("FAIL rnd_xy@%0d: got %0d,%0d want %0d,%0d", n, bltX, bltY, mX, mY); end
      nVec++; if (hitPulse !== mPulse) begin nErr++; $display("FAIL rnd_pulse@%0d: got %b want %b", n, hitPulse, mPulse); end
      nVec++; if (hitCnt !== CW'(mHitCnt)) begin nErr++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, hitCnt, mHitCnt); end
      nVec++; if (freeCnt !== 5'(freeCount())) begin nErr++; $display("FAIL rnd_free@%0d: got %0d want %0d", n, freeCnt, freeCount()); end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_fire_basic();
    test_fill();
    test_kill();
    test_border();
    test_double_kill();
`ifdef BOLT_COOLDOWN_EN
    test_cooldown();
`endif
    test_flush();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
